// File: rtl/i2s_rx.sv
// i2s_rx: I2S slave receiver oversampled in the clk domain, one parallel sample per slot.
// Build option I2S_RX_RIGHT_EN: when defined, right slots are emitted too (default is mono left).
module i2s_rx #(
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i2s_bclk,
  input  logic                i2s_lrclk,
  input  logic                i2s_sd,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_right,
  output logic                sample_valid,
  output logic                frame_err
);
  // state | meaning
  // IDLE  | unsynchronised, waiting for a left-slot start
  // SHIFT | capturing data bits of the current slot
  // SKIP  | sample delivered, counting pad bits up to the slot end
  typedef enum logic [1:0] {IDLE, SHIFT, SKIP} state_t;

  localparam int CNT_W = $clog2(SLOT_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_W - 1);
  localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(SAMPLE_W);

`ifdef I2S_RX_RIGHT_EN
  localparam logic RIGHT_EN = 1'b1;
`else
  localparam logic RIGHT_EN = 1'b0;
`endif

  logic [2:0]          bclk_q, bclk_d;
  logic [1:0]          lr_sync_q, lr_sync_d;
  logic [1:0]          sd_sync_q, sd_sync_d;
  logic                lr_prev_q, lr_prev_d;
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic                chan_q, chan_d;
  logic                cap_pend_q, cap_pend_d;
  logic                pend_right_q, pend_right_d;
  logic                err_pend_q, err_pend_d;
  logic [SAMPLE_W-1:0] sample_data_q, sample_data_d;
  logic                sample_right_q, sample_right_d;
  logic                sample_valid_q, sample_valid_d;
  logic                frame_err_q, frame_err_d;

  logic                bclk_rise, lr_s, sd_s, lr_chg, cap_ok;
  logic [CNT_W-1:0]    cnt_inc;
  logic [SAMPLE_W-1:0] shift_nxt;

  assign bclk_rise = bclk_q[1] & ~bclk_q[2];
  assign lr_s      = lr_sync_q[1];
  assign sd_s      = sd_sync_q[1];
  assign lr_chg    = lr_s ^ lr_prev_q;
  assign cap_ok    = ~chan_q | RIGHT_EN;
  assign cnt_inc   = bit_cnt_q + CNT_W'(1);
  assign shift_nxt = SAMPLE_W'({shift_q, sd_s});

  always_comb begin
    bclk_d         = {bclk_q[1:0], i2s_bclk};
    lr_sync_d      = {lr_sync_q[0], i2s_lrclk};
    sd_sync_d      = {sd_sync_q[0], i2s_sd};
    lr_prev_d      = lr_prev_q;
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    chan_d         = chan_q;
    cap_pend_d     = 1'b0;
    pend_right_d   = pend_right_q;
    err_pend_d     = 1'b0;
    sample_data_d  = sample_data_q;
    sample_right_d = sample_right_q;
    sample_valid_d = cap_pend_q;
    frame_err_d    = err_pend_q;

    // Outputs trail the deciding bit-clock edge by one cycle.
    if (cap_pend_q) begin
      sample_data_d  = shift_q;
      sample_right_d = pend_right_q & RIGHT_EN;
    end

    if (bclk_rise) begin
      lr_prev_d = lr_s;
      case (state_q)
        IDLE: begin
          if (lr_chg && !lr_s) begin
            state_d   = SHIFT;
            bit_cnt_d = '0;
            chan_d    = 1'b0;
          end
        end
        SHIFT, SKIP: begin
          if (lr_chg) begin
            if (bit_cnt_q == CNT_LAST) begin
              // Only reachable in SHIFT when the sample fills the whole slot.
              if (state_q == SHIFT) begin
                shift_d      = shift_nxt;
                cap_pend_d   = cap_ok;
                pend_right_d = chan_q;
              end
              state_d   = SHIFT;
              bit_cnt_d = '0;
              chan_d    = lr_s;
            end else begin
              err_pend_d = 1'b1;
              state_d    = IDLE;
              bit_cnt_d  = '0;
            end
          end else if (bit_cnt_q == CNT_LAST) begin
            err_pend_d = 1'b1;
            state_d    = IDLE;
            bit_cnt_d  = '0;
          end else begin
            bit_cnt_d = cnt_inc;
            if (state_q == SHIFT) begin
              shift_d = shift_nxt;
              if (cnt_inc == CNT_CAP) begin
                cap_pend_d   = cap_ok;
                pend_right_d = chan_q;
                state_d      = SKIP;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_q         <= '0;
      lr_sync_q      <= '0;
      sd_sync_q      <= '0;
      lr_prev_q      <= 1'b0;
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      chan_q         <= 1'b0;
      cap_pend_q     <= 1'b0;
      pend_right_q   <= 1'b0;
      err_pend_q     <= 1'b0;
      sample_data_q  <= '0;
      sample_right_q <= 1'b0;
      sample_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      bclk_q         <= bclk_d;
      lr_sync_q      <= lr_sync_d;
      sd_sync_q      <= sd_sync_d;
      lr_prev_q      <= lr_prev_d;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      chan_q         <= chan_d;
      cap_pend_q     <= cap_pend_d;
      pend_right_q   <= pend_right_d;
      err_pend_q     <= err_pend_d;
      sample_data_q  <= sample_data_d;
      sample_right_q <= sample_right_d;
      sample_valid_q <= sample_valid_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign sample_data  = sample_data_q;
  assign sample_right = sample_right_q;
  assign sample_valid = sample_valid_q;
  assign frame_err    = frame_err_q;

endmodule
